// File: rtl/axi_pinmux_ctrl_if.sv
// AXI4-Lite slave bus bundle for the pin multiplexer register block.
interface axi_pinmux_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_pinmux_ctrl.sv
// AXI4-Lite pin multiplexer: per-pad function select, GPIO out/oe/in, sticky lock.
// One lane instance per pad does the registered mux; the top holds the register file.
module axi_pinmux_lane #(
  parameter int NUM_FUNCS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           sel,
  input  logic                 gpio_o,
  input  logic                 gpio_oe,
  input  logic [NUM_FUNCS-2:0] fo,
  input  logic [NUM_FUNCS-2:0] foe,
  input  logic                 pad_i,
  output logic                 pad_o,
  output logic                 pad_oe,
  output logic [NUM_FUNCS-2:0] fi
);
  logic                 pad_o_d, pad_o_q, pad_oe_d, pad_oe_q;
  logic [NUM_FUNCS-2:0] fi_d, fi_q;

  // Select codes at or beyond NUM_FUNCS fall through to the all-zero default (pad tristated).
  always_comb begin
    pad_o_d  = 1'b0;
    pad_oe_d = 1'b0;
    fi_d     = '0;
    if (sel == 4'd0) begin
      pad_o_d  = gpio_o;
      pad_oe_d = gpio_oe;
    end
    for (int k = 1; k < NUM_FUNCS; k++) begin
      if (sel == 4'(k)) begin
        pad_o_d     = fo[k-1];
        pad_oe_d    = foe[k-1];
        fi_d[k-1]   = pad_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pad_o_q  <= 1'b0;
      pad_oe_q <= 1'b0;
      fi_q     <= '0;
    end else begin
      pad_o_q  <= pad_o_d;
      pad_oe_q <= pad_oe_d;
      fi_q     <= fi_d;
    end
  end

  assign pad_o  = pad_o_q;
  assign pad_oe = pad_oe_q;
  assign fi     = fi_q;
endmodule

module axi_pinmux_ctrl #(
  parameter int NUM_PINS           = 16,
  parameter int NUM_FUNCS          = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  axi_pinmux_ctrl_if.slave                  s_axi,
  input  logic [NUM_PINS-1:0]               pad_i,
  output logic [NUM_PINS-1:0]               pad_o,
  output logic [NUM_PINS-1:0]               pad_oe,
  input  logic [NUM_PINS*(NUM_FUNCS-1)-1:0] func_o,
  input  logic [NUM_PINS*(NUM_FUNCS-1)-1:0] func_oe,
  output logic [NUM_PINS*(NUM_FUNCS-1)-1:0] func_i
);
  localparam int         NF1         = NUM_FUNCS - 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e                      w_state_d, w_state_q;
  r_state_e                      r_state_d, r_state_q;
  logic [1:0]                    bresp_d, bresp_q, rresp_d, rresp_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_d, rdata_q;
  logic [NUM_PINS-1:0][3:0]      sel_d, sel_q;
  logic [NUM_PINS-1:0]           gpio_out_d, gpio_out_q, gpio_oe_d, gpio_oe_q;
  logic [NUM_PINS-1:0]           sync1_d, sync1_q, sync2_d, sync2_q;
  logic                          lock_d, lock_q;
  logic                          aw_hs, ar_hs, rd_err;
  logic [31:0]                   rd_data;
  int                            wr_word, rd_word;
  logic                          unused;

  assign unused = ^{s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};

  always_comb begin
    wr_word = int'(s_axi.AWADDR[C_S_AXI_ADDR_WIDTH-1:2]);
    rd_word = int'(s_axi.ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
  end

  // Write path: address and data are taken together in one cycle, register updated on that edge.
  always_comb begin
    w_state_d  = w_state_q;
    bresp_d    = bresp_q;
    sel_d      = sel_q;
    gpio_out_d = gpio_out_q;
    gpio_oe_d  = gpio_oe_q;
    lock_d     = lock_q;
    aw_hs      = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (!ARESET && s_axi.AWVALID && s_axi.WVALID) begin
          aw_hs     = 1'b1;
          w_state_d = W_RESP;
          bresp_d   = RESP_OKAY;
          case (wr_word)
            0, 1, 2, 3: begin
              if (lock_q) bresp_d = RESP_SLVERR;
              else begin
                for (int p = 0; p < NUM_PINS; p++)
                  if ((p / 8) == wr_word && s_axi.WSTRB[(p % 8) / 2])
                    sel_d[p] = s_axi.WDATA[4*(p%8) +: 4];
              end
            end
            4: begin
              if (lock_q) bresp_d = RESP_SLVERR;
              else begin
                for (int i = 0; i < NUM_PINS; i++)
                  if (s_axi.WSTRB[i/8]) gpio_out_d[i] = s_axi.WDATA[i];
              end
            end
            5: begin
              if (lock_q) bresp_d = RESP_SLVERR;
              else begin
                for (int i = 0; i < NUM_PINS; i++)
                  if (s_axi.WSTRB[i/8]) gpio_oe_d[i] = s_axi.WDATA[i];
              end
            end
            7:       if (s_axi.WSTRB[0] && s_axi.WDATA[0]) lock_d = 1'b1;
            default: bresp_d = RESP_SLVERR;
          endcase
        end
      end
      W_RESP: if (s_axi.BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (rd_word)
      0, 1, 2, 3: begin
        for (int p = 0; p < NUM_PINS; p++)
          if ((p / 8) == rd_word) rd_data[4*(p%8) +: 4] = sel_q[p];
      end
      4:       rd_data[NUM_PINS-1:0] = gpio_out_q;
      5:       rd_data[NUM_PINS-1:0] = gpio_oe_q;
      6:       rd_data[NUM_PINS-1:0] = sync2_q;
      7:       rd_data[0]            = lock_q;
      default: rd_err                = 1'b1;
    endcase
  end

  // Read data is captured from the current register values, so a same-cycle write is not seen.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    ar_hs     = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (!ARESET && s_axi.ARVALID) begin
          ar_hs     = 1'b1;
          r_state_d = R_DATA;
          rdata_d   = rd_data;
          rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
        end
      end
      R_DATA:  if (s_axi.RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    sync1_d = pad_i;
    sync2_d = sync1_q;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      bresp_q    <= RESP_OKAY;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      sel_q      <= '0;
      gpio_out_q <= '0;
      gpio_oe_q  <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      lock_q     <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      bresp_q    <= bresp_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      sel_q      <= sel_d;
      gpio_out_q <= gpio_out_d;
      gpio_oe_q  <= gpio_oe_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      lock_q     <= lock_d;
    end
  end

  assign s_axi.AWREADY = aw_hs;
  assign s_axi.WREADY  = aw_hs;
  assign s_axi.BVALID  = (w_state_q == W_RESP);
  assign s_axi.BRESP   = bresp_q;
  assign s_axi.ARREADY = ar_hs;
  assign s_axi.RVALID  = (r_state_q == R_DATA);
  assign s_axi.RDATA   = rdata_q;
  assign s_axi.RRESP   = rresp_q;

  // Peripheral buses are packed function-major; regroup them per pin for the lanes.
  logic [NUM_PINS-1:0][NF1-1:0] lane_fo, lane_foe, lane_fi;

  for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
    for (genvar k = 0; k < NF1; k++) begin : g_fn
      assign lane_fo[p][k]          = func_o[k*NUM_PINS + p];
      assign lane_foe[p][k]         = func_oe[k*NUM_PINS + p];
      assign func_i[k*NUM_PINS + p] = lane_fi[p][k];
    end
    axi_pinmux_lane #(.NUM_FUNCS(NUM_FUNCS)) u_lane (
      .clk     (ACLK),
      .rst     (ARESET),
      .sel     (sel_q[p]),
      .gpio_o  (gpio_out_q[p]),
      .gpio_oe (gpio_oe_q[p]),
      .fo      (lane_fo[p]),
      .foe     (lane_foe[p]),
      .pad_i   (pad_i[p]),
      .pad_o   (pad_o[p]),
      .pad_oe  (pad_oe[p]),
      .fi      (lane_fi[p])
    );
  end
endmodule
